instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Consumer end of the program counter interface: takes inst_addr from
//   program_counter and drives Pc_Ld/Pc_addr_in back to it. Fetches one
//   instruction per address from instruction memory (req/ack handshake) and
//   presents it to the decoder (valid/ready handshake). Computes the next PC
//   (sequential +1 or taken-branch target) and holds the PC by reloading it
//   while a fetch or decode is stalled.
// PARAMETERS
//   ADDR_W    16  instruction address width (matches inst_addr)
//   DATA_W    16  instruction word width
//   MAX_WAIT  8   cycles in FETCH without Mem_Ack before timeout/retry (>=2)
// PORTS
//   clk          in   1        rising-edge clock
//   Fetch_Rst    in   1        asynchronous, active-high reset
//   inst_addr    in   ADDR_W   current PC value from program_counter
//   Pc_Ld        out  1        PC load enable to program_counter
//   Pc_addr_in   out  ADDR_W   PC load value to program_counter
//   Mem_Req      out  1        instruction memory read request
//   Mem_Addr     out  ADDR_W   instruction memory read address
//   Mem_Ack      in   1        memory read done, Mem_Data valid this cycle
//   Mem_Data     in   DATA_W   instruction word from memory
//   Inst_Out     out  DATA_W   fetched instruction to decoder
//   Inst_Valid   out  1        Inst_Out valid
//   Inst_Ready   in   1        decoder accepts Inst_Out
//   Br_Taken     in   1        decoder: redirect fetch to Br_Target
//   Br_Target    in   ADDR_W   branch/jump target address
//   Fetch_Err    out  1        one-cycle pulse on memory timeout
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE; Pc_Ld, Pc_addr_in, Mem_Req,
//     Mem_Addr, Inst_Out, Inst_Valid, Fetch_Err, fetch_addr, wait_cnt = 0.
//     Reset is asynchronous at any time, incl. mid-FETCH/HOLD: all of the above
//     clear immediately, with no pending request carried over.
//   - IDLE (1 cycle after reset release): fetch_addr<=inst_addr;
//     Pc_Ld<=1, Pc_addr_in<=inst_addr; Mem_Req<=1, Mem_Addr<=inst_addr; ->FETCH.
//   - After IDLE, Pc_Ld stays 1 in every state and Pc_addr_in always equals
//     fetch_addr. The PC is fully slaved and never free-runs.
//   - FETCH: Mem_Req=1 and Mem_Addr is held stable until Mem_Ack.
//     Mem_Ack=1: Inst_Out<=Mem_Data, Inst_Valid<=1, Mem_Req<=0, wait_cnt<=0
//     -> HOLD.
//     Else wait_cnt++. When wait_cnt==MAX_WAIT-1 without ack: Fetch_Err<=1
//     (1 cycle), Mem_Req<=0, wait_cnt<=0 -> RETRY.
//     Mem_Ack on the timeout cycle: the ack wins and no error is raised.
//   - RETRY (1 cycle): Mem_Req<=1, same Mem_Addr -> FETCH.
//   - HOLD: Inst_Valid=1. Inst_Out, Mem_Addr and Pc_addr_in are stable until
//     Inst_Ready=1. On handshake (Inst_Valid & Inst_Ready):
//     next = Br_Taken ? Br_Target : fetch_addr+1 (mod 2^ADDR_W, FFFF->0000);
//     fetch_addr, Pc_addr_in, Mem_Addr <= next; Mem_Req<=1; Inst_Valid<=0
//     -> FETCH.
//   - Br_Taken/Br_Target are sampled only on the handshake cycle.
//   - Mem_Ack while Mem_Req=0 is ignored.
//   - Best-case throughput: 1 instruction per 2 cycles (ack in the first FETCH
//     cycle).
// TESTING
//   1 reset with inst_addr=16'h0F0F, release -> after IDLE: Mem_Req=1,
//     Mem_Addr=0F0F, Pc_Ld=1, Pc_addr_in=0F0F.
//   2 Mem_Ack after 2 cycles with Mem_Data=16'hA5A5, Inst_Ready=1, Br_Taken=0
//     -> Inst_Out=A5A5 valid 1 cycle; then Mem_Addr=Pc_addr_in=0F10.
//   3 Inst_Ready low for 5 cycles -> Inst_Valid=1 and Inst_Out, Pc_addr_in
//     stable throughout; Mem_Req=0.
//   4 handshake with Br_Taken=1, Br_Target=16'h0100 -> Mem_Addr=0100,
//     Pc_addr_in=0100.
//   5 fetch at FFFF, no branch -> next Mem_Addr=0000; no ack for MAX_WAIT=8
//     cycles -> Fetch_Err pulse, Mem_Req low 1 cycle, re-request same address.
//   6 Fetch_Rst asserted mid-FETCH -> all outputs 0 without waiting for clk;
//     on release the IDLE sequence restarts.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: slaves the program counter, fetches one word per
// address over a req/ack memory port, hands it to the decoder over
// valid/ready, and retries a fetch that times out.
module instruction_fetch_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              Fetch_Rst,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              Pc_Ld,
  output logic [ADDR_W-1:0] Pc_addr_in,
  output logic              Mem_Req,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Inst_Out,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic              Br_Taken,
  input  logic [ADDR_W-1:0] Br_Target,
  output logic              Fetch_Err
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RETRY,
    HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W-1:0]  wait_cnt;

  // Next PC: branch target when taken, otherwise sequential (wraps at the top)
  always_comb begin
    next_addr = Br_Taken ? Br_Target : fetch_addr + ADDR_W'(1);
  end

  // Fetch sequencer with registered outputs; Fetch_Err defaults low so it pulses
  always_ff @(posedge clk or posedge Fetch_Rst) begin
    if (Fetch_Rst) begin
      state      <= IDLE;
      Pc_Ld      <= 1'b0;
      Pc_addr_in <= '0;
      Mem_Req    <= 1'b0;
      Mem_Addr   <= '0;
      Inst_Out   <= '0;
      Inst_Valid <= 1'b0;
      Fetch_Err  <= 1'b0;
      fetch_addr <= '0;
      wait_cnt   <= '0;
    end else begin
      Fetch_Err <= 1'b0;
      unique case (state)
        IDLE: begin
          fetch_addr <= inst_addr;
          Pc_Ld      <= 1'b1;
          Pc_addr_in <= inst_addr;
          Mem_Req    <= 1'b1;
          Mem_Addr   <= inst_addr;
          state      <= FETCH;
        end
        FETCH: begin
          // an ack arriving on the timeout cycle takes priority over the error
          if (Mem_Ack) begin
            Inst_Out   <= Mem_Data;
            Inst_Valid <= 1'b1;
            Mem_Req    <= 1'b0;
            wait_cnt   <= '0;
            state      <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            Fetch_Err <= 1'b1;
            Mem_Req   <= 1'b0;
            wait_cnt  <= '0;
            state     <= RETRY;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RETRY: begin
          Mem_Req <= 1'b1;
          state   <= FETCH;
        end
        HOLD: begin
          if (Inst_Ready) begin
            fetch_addr <= next_addr;
            Pc_addr_in <= next_addr;
            Mem_Addr   <= next_addr;
            Mem_Req    <= 1'b1;
            Inst_Valid <= 1'b0;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              Fetch_Rst;
  logic [ADDR_W-1:0] inst_addr;
  logic              Pc_Ld;
  logic [ADDR_W-1:0] Pc_addr_in;
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_Data;
  logic [DATA_W-1:0] Inst_Out;
  logic              Inst_Valid;
  logic              Inst_Ready;
  logic              Br_Taken;
  logic [ADDR_W-1:0] Br_Target;
  logic              Fetch_Err;

  instruction_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .Fetch_Rst (Fetch_Rst),
    .inst_addr (inst_addr),
    .Pc_Ld     (Pc_Ld),
    .Pc_addr_in(Pc_addr_in),
    .Mem_Req   (Mem_Req),
    .Mem_Addr  (Mem_Addr),
    .Mem_Ack   (Mem_Ack),
    .Mem_Data  (Mem_Data),
    .Inst_Out  (Inst_Out),
    .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready),
    .Br_Taken  (Br_Taken),
    .Br_Target (Br_Target),
    .Fetch_Err (Fetch_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: "started" (PC slaved), an outstanding request, a held
  // instruction, cycles spent waiting for memory, and the current address.
  bit          m_started;
  bit          m_req;
  bit          m_valid;
  bit          m_err;
  logic [15:0] m_inst;
  int          m_addr;
  int          m_waited;

  task automatic model_reset();
    m_started = 0; m_req = 0; m_valid = 0; m_err = 0;
    m_inst = '0; m_addr = 0; m_waited = 0;
  endtask

  task automatic model_update();
    m_err = 0;
    if (!m_started) begin
      m_started = 1;
      m_addr    = int'(inst_addr);
      m_req     = 1;
    end else if (m_req) begin
      if (Mem_Ack) begin
        m_inst = Mem_Data; m_valid = 1; m_req = 0; m_waited = 0;
      end else if (m_waited == MAX_WAIT - 1) begin
        m_err = 1; m_req = 0; m_waited = 0;
      end else begin
        m_waited = m_waited + 1;
      end
    end else if (m_valid) begin
      if (Inst_Ready) begin
        m_addr  = Br_Taken ? int'(Br_Target) : (m_addr + 1) % 65536;
        m_req   = 1;
        m_valid = 0;
      end
    end else begin
      m_req = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    logic [15:0] ea;
    ea = 16'(m_addr);
    chk("pc_ld",      32'(Pc_Ld),      32'(m_started));
    chk("pc_addr_in", 32'(Pc_addr_in), 32'(ea));
    chk("mem_req",    32'(Mem_Req),    32'(m_req));
    chk("mem_addr",   32'(Mem_Addr),   32'(ea));
    chk("inst_out",   32'(Inst_Out),   32'(m_inst));
    chk("inst_valid", 32'(Inst_Valid), 32'(m_valid));
    chk("fetch_err",  32'(Fetch_Err),  32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (Fetch_Rst) model_reset();
    else model_update();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse between clock edges, released before the next edge
  task automatic reset_pulse();
    #2 Fetch_Rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 Fetch_Rst = 1'b0;
  endtask

  initial begin
    int ack_pct;
    model_reset();
    Fetch_Rst  = 1'b1;
    inst_addr  = 16'h0F0F;
    Mem_Ack    = 1'b0;
    Mem_Data   = '0;
    Inst_Ready = 1'b0;
    Br_Taken   = 1'b0;
    Br_Target  = '0;

    // 1: reset state, then IDLE loads the PC value
    step();
    step();
    chk("rst_pc_ld", 32'(Pc_Ld), 32'h0);
    chk("rst_req",   32'(Mem_Req), 32'h0);
    Fetch_Rst = 1'b0;
    step();
    chk("t1_req",  32'(Mem_Req), 32'h1);
    chk("t1_addr", 32'(Mem_Addr), 32'h0F0F);
    chk("t1_pcld", 32'(Pc_Ld), 32'h1);
    chk("t1_pcin", 32'(Pc_addr_in), 32'h0F0F);

    // 2: ack on the second fetch cycle, decoder ready
    step();
    Mem_Ack = 1'b1; Mem_Data = 16'hA5A5; Inst_Ready = 1'b1; Br_Taken = 1'b0;
    step();
    chk("t2_valid", 32'(Inst_Valid), 32'h1);
    chk("t2_inst",  32'(Inst_Out), 32'hA5A5);
    Mem_Ack = 1'b0;
    step();
    chk("t2_valid_drop", 32'(Inst_Valid), 32'h0);
    chk("t2_addr", 32'(Mem_Addr), 32'h0F10);
    chk("t2_pcin", 32'(Pc_addr_in), 32'h0F10);

    // 3: decoder stalls 5 cycles; stray acks while not requesting are ignored
    Inst_Ready = 1'b0; Mem_Ack = 1'b1; Mem_Data = 16'h1234;
    step();
    Mem_Data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", 32'(Inst_Valid), 32'h1);
      chk("t3_inst",  32'(Inst_Out), 32'h1234);
      chk("t3_pcin",  32'(Pc_addr_in), 32'h0F10);
      chk("t3_req",   32'(Mem_Req), 32'h0);
    end

    // 4: taken branch on the handshake
    Mem_Ack = 1'b0; Inst_Ready = 1'b1; Br_Taken = 1'b1; Br_Target = 16'h0100;
    step();
    chk("t4_addr", 32'(Mem_Addr), 32'h0100);
    chk("t4_pcin", 32'(Pc_addr_in), 32'h0100);

    // 5: branch to FFFF, sequential wrap to 0000, then a memory timeout
    Mem_Ack = 1'b1; Mem_Data = 16'hBEEF; Br_Taken = 1'b1; Br_Target = 16'hFFFF;
    step();
    step();
    chk("t5_addr_ffff", 32'(Mem_Addr), 32'hFFFF);
    Br_Taken = 1'b0;
    step();
    step();
    chk("t5_wrap", 32'(Mem_Addr), 32'h0000);
    Mem_Ack = 1'b0;
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      step();
      chk("t5_wait_err", 32'(Fetch_Err), 32'h0);
      chk("t5_wait_req", 32'(Mem_Req), 32'h1);
    end
    step();
    chk("t5_err", 32'(Fetch_Err), 32'h1);
    chk("t5_req_low", 32'(Mem_Req), 32'h0);
    chk("t5_addr_kept", 32'(Mem_Addr), 32'h0000);
    step();
    chk("t5_err_pulse", 32'(Fetch_Err), 32'h0);
    chk("t5_rereq", 32'(Mem_Req), 32'h1);
    chk("t5_readdr", 32'(Mem_Addr), 32'h0000);

    // 6: asynchronous reset mid-fetch, then the IDLE sequence restarts
    step();
    #3 Fetch_Rst = 1'b1;
    #1;
    model_reset();
    chk("t6_req",   32'(Mem_Req), 32'h0);
    chk("t6_pcld",  32'(Pc_Ld), 32'h0);
    chk("t6_addr",  32'(Mem_Addr), 32'h0);
    compare_all();
    inst_addr = 16'h0A0A;
    step();
    Fetch_Rst = 1'b0;
    step();
    chk("t6_idle_addr", 32'(Mem_Addr), 32'h0A0A);
    chk("t6_idle_req",  32'(Mem_Req), 32'h1);

    // Random traffic; ack likelihood varies per block so timeouts also occur
    for (int blk = 0; blk < 30; blk++) begin
      ack_pct = $urandom_range(0, 9);
      for (int c = 0; c < 100; c++) begin
        Mem_Ack    = ($urandom_range(0, 9) < ack_pct);
        Mem_Data   = 16'($urandom);
        Inst_Ready = ($urandom_range(0, 9) < 6);
        Br_Taken   = ($urandom_range(0, 3) == 0);
        Br_Target  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        inst_addr  = 16'($urandom);
        if ($urandom_range(0, 199) == 0) reset_pulse();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
